// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM states, the expected
// truth table of Y = (ab)' + cd', and sizing constants.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit i is the expected y for {a,b,c,d} == i; only 12, 13 and 15 evaluate to 0.
  localparam logic [15:0] EXP_TABLE = 16'h4FFF;
  localparam logic [3:0]  IDX_LAST  = 4'd15;
  localparam logic [4:0]  ERR_MAX   = 5'd16;

  function automatic logic exp_y(input logic [3:0] idx);
    return EXP_TABLE[idx];
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, counter debouncer and a
// single-cycle pulse on each accepted press.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Steps {a,b,c,d} through all 16 combinations, captures the expression block's
// y into a truth table and counts samples that disagree with the expected function.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode_auto,
  input  logic        step_btn,
  input  logic        y_in,
  output logic [3:0]  abcd,
  output logic [15:0] truth_table,
  output logic        busy,
  output logic        done,
  output logic [4:0]  err_count,
  output logic        err
);

  localparam int unsigned        PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           abcd_q, abcd_d;
  logic [15:0]          table_q, table_d;
  logic [4:0]           errc_q, errc_d;
  logic                 err_q, err_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 step_pulse;
  logic                 unused_step_level;
  logic                 advance;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (step_btn),
    .btn_level(unused_step_level),
    .btn_pulse(step_pulse)
  );

  // One event source per cycle, picked by the current mode, so a mode change cannot double-advance.
  always_comb begin
    advance = 1'b0;
    if (state_q == ST_WAIT) begin
      advance = mode_auto ? (presc_q == PRESC_LAST) : step_pulse;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abcd_d  = abcd_q;
    table_d = table_q;
    errc_d  = errc_q;
    err_d   = err_q;
    presc_d = presc_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d   = '0;
          abcd_d  = '0;
          table_d = '0;
          errc_d  = '0;
          err_d   = 1'b0;
          state_d = ST_APPLY;
        end
      end

      ST_APPLY: begin
        abcd_d  = idx_q;
        presc_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (advance) begin
          table_d[idx_q] = y_in;
          if (y_in != exp_y(idx_q)) begin
            err_d = 1'b1;
            if (errc_q != ERR_MAX) errc_d = errc_q + 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_APPLY;
          end
        end else if (mode_auto) begin
          presc_d = presc_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      abcd_q  <= '0;
      table_q <= '0;
      errc_q  <= '0;
      err_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abcd_q  <= abcd_d;
      table_q <= table_d;
      errc_q  <= errc_d;
      err_q   <= err_d;
      presc_q <= presc_d;
    end
  end

  assign abcd        = abcd_q;
  assign truth_table = table_q;
  assign busy        = (state_q == ST_APPLY) || (state_q == ST_WAIT);
  assign done        = (state_q == ST_DONE);
  assign err_count   = errc_q;
  assign err         = err_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: auto runs are checked every cycle against a
// timeline model of the run; manual and reset behaviour use directed checks.
module tb_truth_table_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int VEC_CYC  = TICK_DIV + 1;
  localparam int RUN_LEN  = 16 * VEC_CYC;

  logic        clk = 1'b0;
  logic        rst, start, mode_auto, step_btn, y_in, fault;
  logic [3:0]  abcd;
  logic [15:0] truth_table;
  logic        busy, done, err;
  logic [4:0]  err_count;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   t0    = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sequencer #(
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode_auto  (mode_auto),
    .step_btn   (step_btn),
    .y_in       (y_in),
    .abcd       (abcd),
    .truth_table(truth_table),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count),
    .err        (err)
  );

  // Golden expression Y = (ab)' + cd', from the vector's bits.
  function automatic logic gold(input int v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return ~(a & b) | (c & ~d);
  endfunction

  // Expression block as seen by the DUT; the fault flips y only for vector 14.
  function automatic logic blk_y(input int v, input logic f);
    return gold(v) ^ (f && (v == 14));
  endfunction

  assign y_in = blk_y(int'(abcd), fault);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model of an auto run: n = clock edges since the start pulse was taken.
  always @(negedge clk) begin : compare
    int n, ns, ec, v;
    logic [15:0] tbl;
    if (chk_en && cyc > t0) begin
      n  = cyc - t0 - 1;
      ns = (n < VEC_CYC) ? 0 : ((n / VEC_CYC > 16) ? 16 : n / VEC_CYC);
      v  = (n == 0) ? 0 : (((n - 1) / VEC_CYC > 15) ? 15 : (n - 1) / VEC_CYC);
      tbl = '0;
      ec  = 0;
      for (int i = 0; i < ns; i++) begin
        tbl[i] = blk_y(i, fault);
        if (blk_y(i, fault) != gold(i)) ec++;
      end
      check("auto_abcd",      32'(abcd),        32'(v));
      check("auto_busy",      32'(busy),        32'(n < RUN_LEN));
      check("auto_done",      32'(done),        32'(n >= RUN_LEN));
      check("auto_table",     32'(truth_table), 32'(tbl));
      check("auto_err_count", 32'(err_count),   32'(ec));
      check("auto_err",       32'(err),         32'(ec != 0));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic start_run(input logic with_model);
    @(negedge clk);
    start  = 1'b1;
    t0     = cyc;
    chk_en = with_model;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic press(input int hi, input int lo);
    step_btn = 1'b1;
    tick(hi);
    step_btn = 1'b0;
    tick(lo);
  endtask

  // Six single-cycle toggles ending opposite to final_level, then hold final_level.
  task automatic bounce(input logic final_level);
    for (int i = 0; i < 6; i++) begin
      step_btn = final_level ^ i[0];
      tick(1);
    end
    step_btn = final_level;
    tick(10);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_abcd"},      32'(abcd),        32'd0);
    check({tag, "_table"},     32'(truth_table), 32'd0);
    check({tag, "_busy"},      32'(busy),        32'd0);
    check({tag, "_done"},      32'(done),        32'd0);
    check({tag, "_err_count"}, 32'(err_count),   32'd0);
    check({tag, "_err"},       32'(err),         32'd0);
  endtask

  initial begin
    // Reset with start and step both active.
    rst = 1'b1; start = 1'b1; step_btn = 1'b1; mode_auto = 1'b1; fault = 1'b0;
    tick(2);
    check_cleared("reset");
    rst = 1'b0; start = 1'b0; step_btn = 1'b0;
    tick(5);
    check("idle_busy", 32'(busy), 32'd0);

    // Auto run with a healthy expression block.
    start_run(1'b1);
    wait_done("auto_ok_done", 120);
    check("auto_ok_table", 32'(truth_table), 32'h4FFF);
    check("auto_ok_errc",  32'(err_count),   32'd0);
    check("auto_ok_abcd",  32'(abcd),        32'd15);
    tick(3);
    chk_en = 1'b0;
    tick(1);

    // Manual run: a one-cycle glitch is rejected, then 16 clean presses.
    mode_auto = 1'b0;
    start_run(1'b0);
    tick(2);
    step_btn = 1'b1;
    tick(1);
    step_btn = 1'b0;
    tick(10);
    check("glitch_no_step", 32'(abcd), 32'd0);
    check("glitch_busy",    32'(busy), 32'd1);
    for (int p = 0; p < 16; p++) begin
      press(8, 8);
      if (p < 15) check("manual_step", 32'(abcd), 32'(p + 1));
    end
    check("manual_done",  32'(done),        32'd1);
    check("manual_table", 32'(truth_table), 32'h4FFF);
    check("manual_errc",  32'(err_count),   32'd0);

    // Bouncy press gives one step; bouncy release gives none.
    start_run(1'b0);
    tick(2);
    bounce(1'b1);
    check("bounce_press_one_step", 32'(abcd), 32'd1);
    bounce(1'b0);
    check("bounce_release_no_step", 32'(abcd), 32'd1);
    check("bounce_busy",            32'(busy), 32'd1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_mid_manual_busy", 32'(busy), 32'd0);

    // Auto run with the faulty block (vector 14 inverted).
    mode_auto = 1'b1;
    fault     = 1'b1;
    start_run(1'b1);
    wait_done("auto_fault_done", 120);
    check("auto_fault_table", 32'(truth_table), 32'h0FFF);
    check("auto_fault_errc",  32'(err_count),   32'd1);
    check("auto_fault_err",   32'(err),         32'd1);
    chk_en = 1'b0;
    tick(1);
    fault = 1'b0;

    // Mid-run start is ignored; reset at vector 7 aborts; a fresh run starts clean.
    start_run(1'b1);
    tick(20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    begin
      int k = 0;
      while (abcd !== 4'd7 && k < 100) begin
        tick(1);
        k++;
      end
    end
    check("reach_abcd_7", 32'(abcd), 32'd7);
    chk_en = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check_cleared("abort");
    start_run(1'b1);
    wait_done("restart_done", 120);
    check("restart_table", 32'(truth_table), 32'h4FFF);
    tick(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
